// File: rtl/commit_ctrl_if.sv
// Commit bus: ROB head fields in, register-file write port, flush and redirect out.
interface commit_ctrl_if #(
  parameter int unsigned ROB_W = 4
);
  // ROB head
  logic             head_valid;
  logic             head_ready;
  logic [ROB_W-1:0] head_rob_id;
  logic             head_has_rd;
  logic [4:0]       head_rd;
  logic [31:0]      head_value;
  logic             head_mispredict;
  logic [31:0]      head_target;
  // Retire / write port / flush
  logic             pop_head;
  logic             need_set_reg_value;
  logic [4:0]       set_value_reg_id;
  logic [31:0]      set_val;
  logic [ROB_W-1:0] set_reg_rob_id;
  logic             clear;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [31:0]      commit_count;

  // Controller side
  modport master (
    input  head_valid, head_ready, head_rob_id, head_has_rd, head_rd, head_value,
    input  head_mispredict, head_target,
    output pop_head, need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
    output clear, redirect_valid, redirect_pc, commit_count
  );

  // ROB / register file side
  modport slave (
    output head_valid, head_ready, head_rob_id, head_has_rd, head_rd, head_value,
    output head_mispredict, head_target,
    input  pop_head, need_set_reg_value, set_value_reg_id, set_val, set_reg_rob_id,
    input  clear, redirect_valid, redirect_pc, commit_count
  );
endinterface

// File: rtl/commit_ctrl.sv
// In-order retirement controller: retires one ready ROB head per cycle, drives the
// register file write port, and on a mispredict redirects the PC and holds clear.
module commit_ctrl #(
  parameter int unsigned ROB_W        = 4,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          rdy,
  commit_ctrl_if.master bus
);

  localparam int unsigned CntW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             need_q, need_d;
  logic [4:0]       reg_id_q, reg_id_d;
  logic [31:0]      val_q, val_d;
  logic [ROB_W-1:0] rob_id_q, rob_id_d;
  logic             clear_q, clear_d;
  logic             redir_q, redir_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [31:0]      count_q, count_d;
  logic             fire;

  // Head is ignored while in reset so no retire is reported during rst.
  assign fire = rdy && !rst && (state_q == StRun) && bus.head_valid && bus.head_ready;

  assign bus.pop_head           = fire;
  assign bus.need_set_reg_value = need_q;
  assign bus.set_value_reg_id   = reg_id_q;
  assign bus.set_val            = val_q;
  assign bus.set_reg_rob_id     = rob_id_q;
  assign bus.clear              = clear_q;
  assign bus.redirect_valid     = redir_q;
  assign bus.redirect_pc        = redir_pc_q;
  assign bus.commit_count       = count_q;

  // Next-state: retire in RUN, count down the flush window in FLUSH.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    need_d     = 1'b0;
    reg_id_d   = reg_id_q;
    val_d      = val_q;
    rob_id_d   = rob_id_q;
    clear_d    = clear_q;
    redir_d    = 1'b0;
    redir_pc_d = redir_pc_q;
    count_d    = count_q;
    if (state_q == StFlush) begin
      if (cnt_q == '0) begin
        clear_d = 1'b0;
        state_d = StRun;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (fire) begin
      need_d   = bus.head_has_rd && (bus.head_rd != 5'd0);
      reg_id_d = bus.head_rd;
      val_d    = bus.head_value;
      rob_id_d = bus.head_rob_id;
      count_d  = count_q + 32'd1;
      // A mispredicted branch still writes its rd (e.g. jalr link).
      if (bus.head_mispredict) begin
        redir_d    = 1'b1;
        redir_pc_d = bus.head_target;
        clear_d    = 1'b1;
        state_d    = StFlush;
        cnt_d      = CntW'(FLUSH_CYCLES - 1);
      end
    end
  end

  // State update; rdy low freezes everything, including held pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      cnt_q      <= '0;
      need_q     <= 1'b0;
      reg_id_q   <= '0;
      val_q      <= '0;
      rob_id_q   <= '0;
      clear_q    <= 1'b0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
      count_q    <= '0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      need_q     <= need_d;
      reg_id_q   <= reg_id_d;
      val_q      <= val_d;
      rob_id_q   <= rob_id_d;
      clear_q    <= clear_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      count_q    <= count_d;
    end
  end

endmodule
